keyboard_encoder: RTL and testbench
===================================

KEYBOARD_ENCODER -- requirements
Module: keyboard_encoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: CLK cycles without a PS/2 falling edge after which a partial frame is discarded.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the ps2_clk and ps2_data synchronizers.
REQ-003 SHALL have port CLK, input, 1: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1: asynchronous PS/2 clock from the keyboard.
REQ-006 SHALL have port ps2_data, input, 1: asynchronous PS/2 data from the keyboard.
REQ-007 SHALL have port keyboard, output, 6: {code[4:0], pressed}, fed to the instruction-memory patch port.
REQ-008 SHALL have port WriteEnable, output, 1: one-cycle pulse telling instruction memory to latch keyboard.
REQ-009 SHALL have port rx_error, output, 1: one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flip-flops before any use, and SHALL detect a PS/2 falling edge as synchronized previous=1, current=0.
REQ-011 SHALL receive frames with a state machine of states IDLE, DATA, PARITY and STOP, sampling ps2_data on each detected falling edge.
REQ-012 In IDLE, the receiver SHALL move to DATA on a falling edge with data=0 (start bit), and SHALL stay in IDLE on a falling edge with data=1.
REQ-013 In DATA, the receiver SHALL shift in 8 bits LSB first, with a 3-bit counter, then move to PARITY.
REQ-014 In PARITY, the receiver SHALL capture the parity bit and move to STOP; the frame is valid only if data and parity together have odd parity.
REQ-015 In STOP, the receiver SHALL return to IDLE; stop=1 with good parity yields a valid byte, and any other case pulses rx_error and discards the byte.
REQ-016 The timeout counter SHALL reset on every falling edge and count while not in IDLE.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES-1, the receiver SHALL return to IDLE, pulse rx_error and discard the partial frame.
REQ-018 A valid byte SHALL reach the decoder in the cycle after the stop-bit edge.
REQ-019 The decoder SHALL have states NORMAL, BREAK, EXT and EXT_BREAK.
REQ-020 In NORMAL, byte 0xF0 SHALL move the decoder to BREAK and byte 0xE0 to EXT.
REQ-021 In EXT, byte 0xF0 SHALL move the decoder to EXT_BREAK, and any other byte SHALL be ignored and return it to NORMAL.
REQ-022 In EXT_BREAK, any byte SHALL be ignored and return the decoder to NORMAL; extended keys are unmapped.
REQ-023 The key map SHALL be: 0x1D->3, 0x1C->4, 0x1B->5, 0x23->6, 0x29->22, 0x5A->30, 0x66->31; every other scan code is unmapped.
REQ-024 Make (NORMAL, mapped, no key held) SHALL: keyboard<={code,1}, record held code, pulse WriteEnable for exactly one cycle in the same cycle keyboard updates.
REQ-025 A make while a key is held (typematic repeat or second key) SHALL be ignored: no WriteEnable and keyboard unchanged.
REQ-026 Break (BREAK state, byte equals the held code) SHALL set keyboard<=6'b000000, clear the held key, pulse WriteEnable and return to NORMAL.
REQ-027 A break of a non-held or unmapped key SHALL return the decoder to NORMAL with no output change.
REQ-028 Unmapped make codes SHALL be ignored.
REQ-029 WriteEnable SHALL never be high on two consecutive cycles, and keyboard SHALL change only in a WriteEnable cycle.
REQ-030 A receive error SHALL not change the decoder state.
REQ-031 Latency from the stop-bit falling edge (synchronized) to WriteEnable SHALL be exactly 2 CLK cycles.

Reset
REQ-032 On reset=1 at a CLK edge: receiver IDLE, decoder NORMAL, counters 0, held key cleared, keyboard=6'b000000, WriteEnable=0, rx_error=0, synchronizers=1.
REQ-033 Reset mid-frame SHALL discard the partial frame, and the next start bit SHALL begin a fresh frame.

Verification
REQ-034 Frame 0x1D with good parity -> WriteEnable pulses once, keyboard=6'b000111.
REQ-035 Frames 0x1D, then 0xF0, 0x1D -> second WriteEnable pulse, keyboard=6'b000000.
REQ-036 Frames 0x5A, 0x5A, 0x5A (typematic repeat) -> exactly one WriteEnable pulse, keyboard=6'b111101.
REQ-037 Frame 0x1C with bad parity -> rx_error pulses once, no WriteEnable, keyboard remains 6'b000000.
REQ-038 Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES -> rx_error pulses; a following 0x66 frame gives keyboard=6'b111111.
REQ-039 Frames 0xE0, 0x75, then 0xE0, 0xF0, 0x75, then 0x15 -> no WriteEnable pulse and keyboard stays 6'b000000.

Source files
------------

// File: rtl/keyboard_encoder.sv
// PS/2 keyboard receiver and scan-code decoder. It turns make and break codes for a
// small key set into one-cycle {code, pressed} writes to the instruction-memory patch port.
module keyboard_encoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] keyboard,
  output logic       WriteEnable,
  output logic       rx_error,
  output logic [1:0] rx_state_dbg,
  output logic [1:0] dec_state_dbg
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   ps2_clk_s, ps2_data_s, fall;

  rx_state_t              rx_state_q, rx_state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          timeout_q, timeout_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [7:0]             byte_q, byte_d;
  logic                   rx_error_q, rx_error_d;

  dec_state_t             dec_state_q, dec_state_d;
  logic                   held_valid_q, held_valid_d;
  logic [7:0]             held_scan_q, held_scan_d;
  logic [5:0]             keyboard_q, keyboard_d;
  logic                   we_q, we_d;
  logic [5:0]             mapped;

  // Returns {hit, code}; hit=0 for every scan code outside the key set.
  function automatic logic [5:0] map_code(input logic [7:0] sc);
    case (sc)
      8'h1D:   map_code = {1'b1, 5'd3};
      8'h1C:   map_code = {1'b1, 5'd4};
      8'h1B:   map_code = {1'b1, 5'd5};
      8'h23:   map_code = {1'b1, 5'd6};
      8'h29:   map_code = {1'b1, 5'd22};
      8'h5A:   map_code = {1'b1, 5'd30};
      8'h66:   map_code = {1'b1, 5'd31};
      default: map_code = 6'b0;
    endcase
  endfunction

  always_comb begin
    clk_sync_d     = clk_sync_q;
    data_sync_d    = data_sync_q;
    clk_sync_d[0]  = ps2_clk;
    data_sync_d[0] = ps2_data;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      clk_sync_d[i]  = clk_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign clk_prev_d = ps2_clk_s;
  assign fall       = clk_prev_q & ~ps2_clk_s;

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    timeout_d    = timeout_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    rx_error_d   = 1'b0;
    if (fall) begin
      timeout_d = '0;
      case (rx_state_q)
        IDLE: begin
          if (!ps2_data_s) begin
            rx_state_d = DATA;
            bit_cnt_d  = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = PARITY;
        end
        PARITY: begin
          parity_d   = ps2_data_s;
          rx_state_d = STOP;
        end
        default: begin
          rx_state_d = IDLE;
          if (ps2_data_s && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            rx_error_d = 1'b1;
          end
        end
      endcase
    end else if (rx_state_q != IDLE) begin
      // A keyboard that stops clocking mid-frame must not wedge the receiver.
      if (timeout_q == TIMEOUT_MAX) begin
        rx_state_d = IDLE;
        timeout_d  = '0;
        rx_error_d = 1'b1;
      end else begin
        timeout_d = timeout_q + 1'b1;
      end
    end
  end

  assign mapped = map_code(byte_q);

  always_comb begin
    dec_state_d  = dec_state_q;
    held_valid_d = held_valid_q;
    held_scan_d  = held_scan_q;
    keyboard_d   = keyboard_q;
    we_d         = 1'b0;
    if (byte_valid_q) begin
      case (dec_state_q)
        NORMAL: begin
          if (byte_q == 8'hF0) begin
            dec_state_d = BREAK;
          end else if (byte_q == 8'hE0) begin
            dec_state_d = EXT;
          end else if (mapped[5] && !held_valid_q) begin
            keyboard_d   = {mapped[4:0], 1'b1};
            held_valid_d = 1'b1;
            held_scan_d  = byte_q;
            we_d         = 1'b1;
          end
        end
        BREAK: begin
          dec_state_d = NORMAL;
          if (held_valid_q && byte_q == held_scan_q) begin
            keyboard_d   = 6'b000000;
            held_valid_d = 1'b0;
            we_d         = 1'b1;
          end
        end
        EXT:     dec_state_d = (byte_q == 8'hF0) ? EXT_BREAK : NORMAL;
        default: dec_state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      rx_state_q   <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timeout_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      rx_error_q   <= 1'b0;
      dec_state_q  <= NORMAL;
      held_valid_q <= 1'b0;
      held_scan_q  <= 8'h00;
      keyboard_q   <= 6'b000000;
      we_q         <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timeout_q    <= timeout_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      rx_error_q   <= rx_error_d;
      dec_state_q  <= dec_state_d;
      held_valid_q <= held_valid_d;
      held_scan_q  <= held_scan_d;
      keyboard_q   <= keyboard_d;
      we_q         <= we_d;
    end
  end

  assign keyboard      = keyboard_q;
  assign WriteEnable   = we_q;
  assign rx_error      = rx_error_q;
  assign rx_state_dbg  = rx_state_q;
  assign dec_state_dbg = dec_state_q;

endmodule

// File: tb/tb_keyboard_encoder.sv
// Directed bench for keyboard_encoder: PS/2 frames are bit-banged slowly against the
// system clock and outputs are checked with immediate assertions on the falling clock edge.
module tb_keyboard_encoder;

  localparam int TIMEOUT = 100;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [5:0] keyboard;
  logic       we;
  logic       rx_error;
  logic [1:0] rx_state_dbg;
  logic [1:0] dec_state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;
  int we_cnt    = 0;
  int err_cnt   = 0;
  int lat;
  logic       prev_we = 1'b0;
  logic [5:0] prev_kb = 6'b0;

  keyboard_encoder #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .CLK          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .keyboard     (keyboard),
    .WriteEnable  (we),
    .rx_error     (rx_error),
    .rx_state_dbg (rx_state_dbg),
    .dec_state_dbg(dec_state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters plus the "one-cycle WriteEnable" and "keyboard only moves with WriteEnable" rules
  always @(negedge clk) begin
    if (we) we_cnt++;
    if (rx_error) err_cnt++;
    if (!reset) begin
      if (we && prev_we) check("we_back_to_back", 32'(we), 32'(0));
      if (keyboard !== prev_kb) check("kb_change_without_we", 32'(we), 32'(1));
    end
    prev_we = we;
    prev_kb = keyboard;
  end

  // Driver: one PS/2 bit; lat returns the negedge index after the falling edge where WriteEnable was seen
  task automatic ps2_bit(input logic b, output int l);
    ps2_data = b;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    l = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (we && l < 0) l = i;
      if (i == 4) ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par, input logic stop_bit,
                            output int l);
    int dummy;
    ps2_bit(1'b0, dummy);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], dummy);
    ps2_bit(good_par ? ~(^b) : (^b), dummy);
    ps2_bit(stop_bit, l);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int l;
    send_frame(b, 1'b1, 1'b1, l);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_keyboard", 32'(keyboard), 32'(0));
    check("reset_we", 32'(we), 32'(0));
    check("reset_rx_error", 32'(rx_error), 32'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_state", 32'(rx_state_dbg), 32'(0));
    check("reset_dec_state", 32'(dec_state_dbg), 32'(0));

    // Make 0x1D -> code 3
    send_frame(8'h1D, 1'b1, 1'b1, lat);
    check("make_1d_latency", 32'(lat), 32'(4));
    check("make_1d_we_cnt", 32'(we_cnt), 32'(1));
    check("make_1d_kb", 32'(keyboard), 32'(6'b000111));

    // Break 0x1D
    send_byte(8'hF0);
    send_frame(8'h1D, 1'b1, 1'b1, lat);
    check("break_1d_latency", 32'(lat), 32'(4));
    check("break_1d_we_cnt", 32'(we_cnt), 32'(2));
    check("break_1d_kb", 32'(keyboard), 32'(0));

    // Typematic repeat of 0x5A
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'h5A);
    check("repeat_5a_we_cnt", 32'(we_cnt), 32'(3));
    check("repeat_5a_kb", 32'(keyboard), 32'(6'b111101));
    send_byte(8'hF0);
    send_byte(8'h5A);
    check("break_5a_we_cnt", 32'(we_cnt), 32'(4));
    check("break_5a_kb", 32'(keyboard), 32'(0));

    // Bad parity
    send_frame(8'h1C, 1'b0, 1'b1, lat);
    check("bad_parity_err_cnt", 32'(err_cnt), 32'(1));
    check("bad_parity_we_cnt", 32'(we_cnt), 32'(4));
    check("bad_parity_kb", 32'(keyboard), 32'(0));

    // Partial frame then timeout
    ps2_bit(1'b0, lat);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, lat);
    check("partial_busy", 32'(rx_state_dbg != 2'd0), 32'(1));
    repeat (TIMEOUT + 20) @(negedge clk);
    check("timeout_err_cnt", 32'(err_cnt), 32'(2));
    check("timeout_rx_idle", 32'(rx_state_dbg), 32'(0));
    send_byte(8'h66);
    check("after_timeout_66_kb", 32'(keyboard), 32'(6'b111111));
    check("after_timeout_we_cnt", 32'(we_cnt), 32'(5));
    send_byte(8'hF0);
    send_byte(8'h66);
    check("break_66_kb", 32'(keyboard), 32'(0));

    // Extended keys and unmapped make are ignored
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'h15);
    check("ext_we_cnt", 32'(we_cnt), 32'(6));
    check("ext_kb", 32'(keyboard), 32'(0));
    check("ext_dec_state", 32'(dec_state_dbg), 32'(0));

    // Reset in the middle of a frame, then a fresh frame
    ps2_bit(1'b0, lat);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_rx_idle", 32'(rx_state_dbg), 32'(0));
    send_byte(8'h1B);
    check("midreset_1b_kb", 32'(keyboard), 32'(6'b001011));
    check("midreset_we_cnt", 32'(we_cnt), 32'(7));
    check("midreset_err_cnt", 32'(err_cnt), 32'(2));

    // Second key while one is held, break of a non-held key
    send_byte(8'h1C);
    check("second_key_kb", 32'(keyboard), 32'(6'b001011));
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("nonheld_break_kb", 32'(keyboard), 32'(6'b001011));
    check("nonheld_break_dec", 32'(dec_state_dbg), 32'(0));
    check("nonheld_we_cnt", 32'(we_cnt), 32'(7));
    send_byte(8'hF0);
    send_byte(8'h1B);
    check("break_1b_kb", 32'(keyboard), 32'(0));
    check("break_1b_we_cnt", 32'(we_cnt), 32'(8));

    // Bad stop bit, with the decoder left in BREAK: the error must not disturb it
    send_byte(8'hF0);
    send_frame(8'h23, 1'b1, 1'b0, lat);
    check("bad_stop_err_cnt", 32'(err_cnt), 32'(3));
    check("bad_stop_dec_break", 32'(dec_state_dbg), 32'(1));
    send_byte(8'h23);
    check("after_err_dec_state", 32'(dec_state_dbg), 32'(0));
    check("after_err_kb", 32'(keyboard), 32'(0));
    check("final_we_cnt", 32'(we_cnt), 32'(8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
